pwm_audio_out: RTL
==================

Name: pwm_audio_out

Overview:
Sample sink and output stage for the synth's 8-bit sample generators (noise, square, triangle).
- Accepts 8-bit samples over a valid/ready handshake and buffers them in a small FIFO.
- Pops one sample per `period` clocks and converts the current sample to a 1-bit PWM stream for the board's audio pin.
- It is the reader end of the sample stream that the generators write.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, 3, width of `level`; equals log2(DEPTH)+1.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
period  input  32  clocks per output sample.
sample_in  input  8  unsigned sample from the generator.
sample_valid  input  1  sample_in is valid this cycle.
sample_ready  output  1  FIFO can accept a sample this cycle.
pwm_out  output  1  registered PWM audio bit.
underrun  output  1  one-cycle pulse when a sample tick finds the FIFO empty.
level  output  CNT_W  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO pointers and count go to 0; sample timer, PWM counter and cur_sample go to 0.
  - pwm_out=0, underrun=0, level=0.
  - sample_ready is combinational from count, so it reads 1 whenever reset is released. FIFO contents need not be cleared.
- Reset mid-operation discards all buffered samples. The first sample tick after release occurs `period` clocks later.
- Handshake:
  - sample_ready = (count != DEPTH); it does not depend on sample_valid.
  - Push occurs on a cycle with sample_valid && sample_ready.
  - sample_in must be captured in that same cycle. The generator may change sample_in freely when sample_valid is low.
- Sample timer:
  - 32-bit counter t. When t >= period-1, a tick fires and t returns to 0; otherwise t increments.
  - period 0 or 1 ticks every cycle.
  - A period change takes effect immediately. Shrinking below the current t forces a tick on the next cycle rather than waiting for a 32-bit wrap.
- On a tick:
  - If count>0: pop the head into cur_sample.
  - If count==0: cur_sample holds its value and underrun=1 for exactly that cycle.
- Simultaneous push and pop:
  - With 0<count<DEPTH, count is unchanged and both operations occur.
  - With count==DEPTH, ready is already low, so only the pop occurs. Ready rises the next cycle.
  - With count==0 and a push, the tick reports underrun. The pushed sample is stored (count becomes 1) and is popped on the next tick.
- FIFO order is strict first-in, first-out. Pointers wrap modulo DEPTH.
- level equals count, registered.
- PWM:
  - 8-bit free-running counter p (0..255, wraps 255→0).
  - pwm_out <= (p < cur_sample), registered, one clock after p.
  - Sample 0 gives constant 0; sample 255 gives 255 high clocks per 256; sample 128 gives 50% duty.
  - A new cur_sample takes effect on the next compare; no re-alignment to the PWM frame.
- Latency:
  - A sample pushed into an empty FIFO reaches cur_sample on the first tick after the push.
  - It affects pwm_out one clock after that tick.

Decomposition:
- Shared package audio_pkg: SAMPLE_W=8 and typedef sample_t (logic [7:0]).
  - Also holds PWM_W=8, which the generators reuse.
- One sub-module, sample_fifo:
  - Parameterised by DEPTH.
  - Ports: clk, reset, push, pop, wdata, rdata, count, full, empty.
  - rdata shows the head combinationally.
- Sample timer and PWM counter remain in pwm_audio_out.

Test Plan:
- Reset check: hold reset=0 with sample_valid=1 → pwm_out=0, level=0, no push; release reset → sample_ready=1 immediately.
- Fill: period=1000, push 0x10,0x20,0x30,0x40 on consecutive cycles → level=4, sample_ready=0. A fifth valid sample is not accepted. After the first tick, level=3 and ready=1 next cycle.
- Ordering and duty: period=512, push 0x00, 0x80, 0xFF → cur_sample follows that order on successive ticks. Over a full 256-clock window, high counts are 0, 128 and 255.
- Underrun: period=4, push one sample 0x40 then stop → that sample plays from the first tick. Each later tick pulses underrun for 1 cycle while pwm duty stays 64/256.
- Simultaneous events: level=DEPTH at a tick with sample_valid=1 → pop only, count DEPTH-1, accept next cycle. Empty at a tick with a push → underrun=1, level=1.
- Period edge cases: period=0 → tick every cycle. t=800 with period changed 1000→100 → tick on the next cycle, then every 100 clocks.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared sample/PWM definitions for the synth's sample generators and output stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    // PWM counter width; generators reuse it to size their own phase counters.
    localparam int PWM_W    = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio samples between the generators and the PWM stage.
// Latency: a pushed word is visible on rdata the cycle after the push when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; full/empty steer the caller.
//
// Ports: clk, reset (async active-low), push/wdata (write side), pop/rdata (read side,
// rdata shows the head combinationally), count (occupancy 0..DEPTH), full, empty.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  sample_t                  wdata,
    output sample_t                  rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    sample_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop against an empty FIFO is dropped even when a push lands the same
    // cycle, so the new word stays queued for the next read.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the natural pointer overflow is the wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule : sample_fifo

// File: rtl/pwm_audio_out.sv
// Audio sink: buffers 8-bit samples, plays one per `period` clocks as a 1-bit PWM stream.
// Latency: a sample pushed into an empty FIFO loads on the next tick, reaches pwm_out one clock later.
// Backpressure: sample_ready = FIFO not full; a tick finding the FIFO empty holds the sample and pulses underrun.
//
// Ports: clk, reset (async active-low), period (clocks per sample), sample_in/sample_valid/
// sample_ready (generator handshake), pwm_out (registered audio bit), underrun (1-cycle pulse),
// level (FIFO occupancy).
module pwm_audio_out
    import audio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       period,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              pwm_out,
    output logic              underrun,
    output logic [CNT_W-1:0]  level
);

    logic [31:0]       t_q, t_d;
    logic [PWM_W-1:0]  p_q, p_d;
    sample_t           cur_sample_q, cur_sample_d;
    logic              pwm_q, pwm_d;
    logic              underrun_q, underrun_d;

    logic              tick;
    logic              push;
    sample_t           head;
    logic              fifo_full;
    logic              fifo_empty;

    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;

    // ">=" rather than "==" so shrinking period below the running count
    // fires on the next cycle instead of waiting for a 32-bit wrap.
    // period 0 would underflow period-1, so 0 and 1 both tick every cycle.
    assign tick = (period <= 32'd1) || (t_q >= (period - 32'd1));

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (tick),
        .wdata (sample_in),
        .rdata (head),
        .count (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        t_d          = tick ? 32'd0 : t_q + 32'd1;
        p_d          = p_q + PWM_W'(1);
        cur_sample_d = cur_sample_q;
        underrun_d   = 1'b0;
        if (tick) begin
            if (fifo_empty) underrun_d   = 1'b1;
            else            cur_sample_d = head;
        end
        // Compare against the live sample with no frame re-alignment.
        pwm_d = (p_q < cur_sample_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_q          <= '0;
            p_q          <= '0;
            cur_sample_q <= '0;
            pwm_q        <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            t_q          <= t_d;
            p_q          <= p_d;
            cur_sample_q <= cur_sample_d;
            pwm_q        <= pwm_d;
            underrun_q   <= underrun_d;
        end
    end

    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;

endmodule : pwm_audio_out
